ysyx_22040237_exu_ctrl: RTL and testbench
=========================================

YSYX_22040237_EXU_CTRL -- requirements
Module: ysyx_22040237_exu_ctrl

Interface
REQ-001 SHALL have parameter MD_TIMEOUT, default 64, meaning the maximum MD_WAIT cycles before a timeout halt (range 2..255).
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port id_valid  in  1  decode offers an instruction.
REQ-005 SHALL have port id_ready  out  1  the controller accepts the instruction this cycle.
REQ-006 SHALL have ports id_is_muldiv, id_ebreak, id_invalid  in  1 each  instruction class flags.
REQ-007 SHALL have port id_rd  in  5  destination register index.
REQ-008 SHALL have port alu_result  in  64  combinational single-cycle EXU result for the offered instruction.
REQ-009 SHALL have ports md_start (out 1, start pulse), md_flush (out 1, abort pulse), md_done (in 1, result valid) and md_result (in 64, iterative mul/div result).
REQ-010 SHALL have ports wb_valid (out 1), wb_ready (in 1), wb_we (out 1), wb_rd (out 5) and wb_data (out 64) for writeback.
REQ-011 SHALL have ports halt (out 1, sticky stop) and halt_code (out 2: 01 ebreak, 10 invalid, 11 mul/div timeout).
REQ-012 SHALL have port retire_cnt  out  32  count of retired instructions.

Function
REQ-013 SHALL implement states IDLE, MD_WAIT, WB and HALT, encoded in a registered state variable.
REQ-014 SHALL drive id_ready=1 only in IDLE; an instruction is accepted when id_valid && id_ready.
REQ-015 On accept, SHALL use class priority id_invalid > id_ebreak > id_is_muldiv > ALU, applied when several flags are set.
REQ-016 Invalid accept SHALL go to HALT with halt_code=10 and SHALL NOT increment retire_cnt.
REQ-017 Ebreak accept SHALL go to HALT with halt_code=01 and SHALL increment retire_cnt by 1.
REQ-018 ALU accept SHALL capture alu_result into wb_data and id_rd into wb_rd on the same edge and go to WB, so wb_valid rises 1 cycle after accept.
REQ-019 Mul/div accept SHALL latch id_rd, go to MD_WAIT, assert md_start for exactly the first MD_WAIT cycle, and clear the timeout counter.
REQ-020 In MD_WAIT, md_done SHALL be ignored during the md_start cycle; on a later md_done=1 the block SHALL capture md_result into wb_data and go to WB.
REQ-021 The timeout counter SHALL increment on each MD_WAIT cycle without a qualifying md_done.
REQ-022 When the timeout counter reaches MD_TIMEOUT, the block SHALL pulse md_flush for 1 cycle, go to HALT with halt_code=11, and produce no writeback.
REQ-023 If md_done and the timeout occur in the same cycle, md_done SHALL take precedence.
REQ-024 In WB, wb_valid=1 and wb_rd, wb_data and wb_we SHALL hold stable until wb_ready=1.
REQ-025 On the WB handshake, the block SHALL go to IDLE and increment retire_cnt by 1; a new instruction is accepted no earlier than the next cycle.
REQ-026 wb_we SHALL be 1 iff wb_rd != 0; an rd=0 instruction still performs the handshake and retires.
REQ-027 retire_cnt SHALL wrap from 0xFFFFFFFF to 0.
REQ-028 HALT SHALL be sticky until reset: halt=1, id_ready=0, wb_valid=0, md_start=0, all inputs ignored.
REQ-029 md_start and md_flush SHALL be registered outputs and never both be 1 in the same cycle.

Reset
REQ-030 While rst=0 at a clock edge, the block SHALL set state=IDLE and zero all of: halt, halt_code, wb_valid, wb_we, wb_rd, wb_data, md_start, md_flush, retire_cnt and the timeout counter.
REQ-031 id_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-032 Reset asserted in MD_WAIT, WB or HALT SHALL abort the operation without a writeback, retire increment or md_flush pulse.

Verification
REQ-033 ALU instruction: rd=5, alu_result=0x1234, wb_ready tied 1 -> wb_valid high 1 cycle after accept with wb_rd=5, wb_data=0x1234, wb_we=1; retire_cnt=1.
REQ-034 Mul/div instruction: rd=7, md_done after 10 cycles, md_result=0xFFFF_0000_0000_0001 -> md_start for exactly 1 cycle, wb_data=0xFFFF000000000001, id_ready=0 throughout.
REQ-035 Backpressure: wb_ready=0 for 5 cycles -> wb_data stable for all 5 cycles, single retire, id_ready=0 until the handshake completes.
REQ-036 Halts: id_ebreak=1 and id_is_muldiv=1 together -> halt=1, halt_code=01, retire_cnt+1, no md_start; id_invalid=1 -> halt_code=10 with no retire.
REQ-037 Timeout: md_done never asserted with MD_TIMEOUT=64 -> md_flush pulse after 64 MD_WAIT cycles, halt_code=11, wb_valid never asserted.
REQ-038 Reset while wb_valid=1 and wb_ready=0 -> next cycle wb_valid=0, retire_cnt=0, id_ready=1.

Source files
------------

// File: rtl/ysyx_22040237_exu_ctrl.sv
// ============================================================================
// ysyx_22040237_exu_ctrl
// ----------------------------------------------------------------------------
// Execute-stage controller. Takes one instruction at a time from decode and
// retires it in one of three ways:
//   - ALU ops take the combinational alu_result and write it back.
//   - Mul/div ops start the iterative unit, wait for its result and write it
//     back. A watchdog stops the core if the unit never answers.
//   - ebreak and invalid ops stop the core with a halt code that software can
//     read.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   id_valid/ready    decode handshake
//   id_is_muldiv,
//   id_ebreak,
//   id_invalid        instruction class flags (priority invalid > ebreak > md)
//   id_rd             destination register index
//   alu_result        single-cycle EXU result for the offered instruction
//   md_start/flush    start / abort pulses to the mul/div unit (registered)
//   md_done/result    mul/div completion and result
//   wb_*              writeback handshake (wb_we = wb_rd != 0)
//   halt, halt_code   sticky stop: 01 ebreak, 10 invalid, 11 mul/div timeout
//   retire_cnt        retired-instruction counter, wraps at 2^32
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | id_ready=1, waiting for an instruction
// MD_WAIT | mul/div in flight; watchdog counting
// WB      | result held on wb_* until wb_ready
// HALT    | stopped until reset; all inputs ignored
// ============================================================================
module ysyx_22040237_exu_ctrl #(
    parameter int unsigned MD_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        id_valid,
    output logic        id_ready,
    input  logic        id_is_muldiv,
    input  logic        id_ebreak,
    input  logic        id_invalid,
    input  logic [4:0]  id_rd,
    input  logic [63:0] alu_result,

    output logic        md_start,
    output logic        md_flush,
    input  logic        md_done,
    input  logic [63:0] md_result,

    output logic        wb_valid,
    input  logic        wb_ready,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_data,

    output logic        halt,
    output logic [1:0]  halt_code,
    output logic [31:0] retire_cnt
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_MD_WAIT = 2'd1;
    localparam logic [1:0] S_WB      = 2'd2;
    localparam logic [1:0] S_HALT    = 2'd3;

    localparam logic [1:0] HC_EBREAK  = 2'b01;
    localparam logic [1:0] HC_INVALID = 2'b10;
    localparam logic [1:0] HC_TIMEOUT = 2'b11;

    localparam logic [7:0] TMO_LIMIT = 8'(MD_TIMEOUT);

    logic [1:0]  state_q,      state_d;
    logic        halt_q,       halt_d;
    logic [1:0]  halt_code_q,  halt_code_d;
    logic        wb_valid_q,   wb_valid_d;
    logic        wb_we_q,      wb_we_d;
    logic [4:0]  wb_rd_q,      wb_rd_d;
    logic [63:0] wb_data_q,    wb_data_d;
    logic        md_start_q,   md_start_d;
    logic        md_flush_q,   md_flush_d;
    logic [31:0] retire_cnt_q, retire_cnt_d;
    logic [7:0]  tmo_cnt_q,    tmo_cnt_d;

    logic        accept;
    logic        md_done_ok;
    logic [7:0]  tmo_inc;

    assign id_ready   = (state_q == S_IDLE);
    assign accept     = id_valid && id_ready;
    // The unit cannot legitimately finish in the cycle it is being started,
    // so a done seen alongside md_start is stale and dropped.
    assign md_done_ok = md_done && !md_start_q;
    assign tmo_inc    = tmo_cnt_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        halt_d       = halt_q;
        halt_code_d  = halt_code_q;
        wb_valid_d   = wb_valid_q;
        wb_we_d      = wb_we_q;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        md_start_d   = 1'b0;
        md_flush_d   = 1'b0;
        retire_cnt_d = retire_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (id_invalid) begin
                        state_d     = S_HALT;
                        halt_d      = 1'b1;
                        halt_code_d = HC_INVALID;
                    end else if (id_ebreak) begin
                        // ebreak itself counts as a retired instruction
                        state_d      = S_HALT;
                        halt_d       = 1'b1;
                        halt_code_d  = HC_EBREAK;
                        retire_cnt_d = retire_cnt_q + 32'd1;
                    end else if (id_is_muldiv) begin
                        state_d    = S_MD_WAIT;
                        wb_rd_d    = id_rd;
                        wb_we_d    = (id_rd != 5'd0);
                        md_start_d = 1'b1;
                        tmo_cnt_d  = 8'd0;
                    end else begin
                        state_d    = S_WB;
                        wb_valid_d = 1'b1;
                        wb_rd_d    = id_rd;
                        wb_we_d    = (id_rd != 5'd0);
                        wb_data_d  = alu_result;
                    end
                end
            end

            S_MD_WAIT: begin
                if (md_done_ok) begin
                    // a result arriving on the watchdog's last cycle still wins
                    state_d    = S_WB;
                    wb_valid_d = 1'b1;
                    wb_data_d  = md_result;
                end else begin
                    tmo_cnt_d = tmo_inc;
                    if (tmo_inc == TMO_LIMIT) begin
                        state_d     = S_HALT;
                        halt_d      = 1'b1;
                        halt_code_d = HC_TIMEOUT;
                        md_flush_d  = 1'b1;
                    end
                end
            end

            S_WB: begin
                if (wb_ready) begin
                    state_d      = S_IDLE;
                    wb_valid_d   = 1'b0;
                    retire_cnt_d = retire_cnt_q + 32'd1;
                end
            end

            default: begin
                // S_HALT: sticky, nothing changes until reset
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            halt_q       <= 1'b0;
            halt_code_q  <= 2'b00;
            wb_valid_q   <= 1'b0;
            wb_we_q      <= 1'b0;
            wb_rd_q      <= 5'd0;
            wb_data_q    <= 64'd0;
            md_start_q   <= 1'b0;
            md_flush_q   <= 1'b0;
            retire_cnt_q <= 32'd0;
            tmo_cnt_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            halt_q       <= halt_d;
            halt_code_q  <= halt_code_d;
            wb_valid_q   <= wb_valid_d;
            wb_we_q      <= wb_we_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            md_start_q   <= md_start_d;
            md_flush_q   <= md_flush_d;
            retire_cnt_q <= retire_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    assign md_start   = md_start_q;
    assign md_flush   = md_flush_q;
    assign wb_valid   = wb_valid_q;
    assign wb_we      = wb_we_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign halt       = halt_q;
    assign halt_code  = halt_code_q;
    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_ysyx_22040237_exu_ctrl.sv
// ============================================================================
// tb_ysyx_22040237_exu_ctrl
// Directed test of the execute controller: ALU writeback, rd=0, backpressure,
// mul/div with stale done, done-vs-watchdog precedence, reset in WB,
// ebreak/invalid halts and the mul/div timeout.
// ============================================================================
module tb_ysyx_22040237_exu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_ready, id_is_muldiv, id_ebreak, id_invalid;
    logic [4:0]  id_rd;
    logic [63:0] alu_result;
    logic        md_start, md_flush, md_done;
    logic [63:0] md_result;
    logic        wb_valid, wb_ready, wb_we;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        halt;
    logic [1:0]  halt_code;
    logic [31:0] retire_cnt;

    int n_checks = 0;
    int n_errors = 0;

    ysyx_22040237_exu_ctrl #(.MD_TIMEOUT(64)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_is_muldiv (id_is_muldiv),
        .id_ebreak    (id_ebreak),
        .id_invalid   (id_invalid),
        .id_rd        (id_rd),
        .alu_result   (alu_result),
        .md_start     (md_start),
        .md_flush     (md_flush),
        .md_done      (md_done),
        .md_result    (md_result),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .halt         (halt),
        .halt_code    (halt_code),
        .retire_cnt   (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // advance one edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    initial begin
        int starts;
        int bad;
        logic [63:0] held;

        rst = 1'b0;
        id_valid = 1'b0; id_is_muldiv = 1'b0; id_ebreak = 1'b0; id_invalid = 1'b0;
        id_rd = 5'd0; alu_result = 64'd0;
        md_done = 1'b0; md_result = 64'd0; wb_ready = 1'b1;
        step(); step();

        check("rst_halt",      64'(halt), 64'd0);
        check("rst_halt_code", 64'(halt_code), 64'd0);
        check("rst_wb_valid",  64'(wb_valid), 64'd0);
        check("rst_wb_data",   wb_data, 64'd0);
        check("rst_md_start",  64'(md_start), 64'd0);
        check("rst_md_flush",  64'(md_flush), 64'd0);
        check("rst_retire",    64'(retire_cnt), 64'd0);
        rst = 1'b1;
        check("rst_id_ready",  64'(id_ready), 64'd1);

        // ALU rd=5
        id_valid = 1'b1; id_rd = 5'd5; alu_result = 64'h1234;
        step();
        id_valid = 1'b0; alu_result = 64'd0;
        check("alu_wb_valid", 64'(wb_valid), 64'd1);
        check("alu_wb_rd",    64'(wb_rd), 64'd5);
        check("alu_wb_data",  wb_data, 64'h1234);
        check("alu_wb_we",    64'(wb_we), 64'd1);
        check("alu_id_ready", 64'(id_ready), 64'd0);
        step();
        check("alu_done_valid", 64'(wb_valid), 64'd0);
        check("alu_retire",     64'(retire_cnt), 64'd1);
        check("alu_idle_ready", 64'(id_ready), 64'd1);

        // ALU rd=0
        id_valid = 1'b1; id_rd = 5'd0; alu_result = 64'hCAFE;
        step();
        id_valid = 1'b0;
        check("rd0_wb_valid", 64'(wb_valid), 64'd1);
        check("rd0_wb_we",    64'(wb_we), 64'd0);
        step();
        check("rd0_retire",   64'(retire_cnt), 64'd2);

        // backpressure
        wb_ready = 1'b0;
        id_valid = 1'b1; id_rd = 5'd3; alu_result = 64'hABCD_0000_1111;
        step();
        id_valid = 1'b0; alu_result = 64'd0;
        held = wb_data;
        check("bp_data", held, 64'hABCD_0000_1111);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (wb_data !== held || wb_valid !== 1'b1 || id_ready !== 1'b0 || retire_cnt !== 32'd2) bad++;
        end
        check("bp_stable", 64'(bad), 64'd0);
        wb_ready = 1'b1;
        step();
        check("bp_release_valid", 64'(wb_valid), 64'd0);
        check("bp_retire",        64'(retire_cnt), 64'd3);
        check("bp_id_ready",      64'(id_ready), 64'd1);

        // mul/div rd=7, stale done during start cycle, real done on cycle 10
        id_valid = 1'b1; id_is_muldiv = 1'b1; id_rd = 5'd7;
        step();
        id_valid = 1'b0; id_is_muldiv = 1'b0;
        check("md_start_first", 64'(md_start), 64'd1);
        starts = 1;
        bad = (id_ready !== 1'b0) ? 1 : 0;
        md_done = 1'b1; md_result = 64'hDEAD;
        for (int k = 2; k <= 10; k++) begin
            step();
            md_done = 1'b0;
            if (md_start) starts++;
            if (id_ready !== 1'b0 || wb_valid !== 1'b0) bad++;
        end
        md_done = 1'b1; md_result = 64'hFFFF_0000_0000_0001;
        step();
        md_done = 1'b0; md_result = 64'd0;
        check("md_start_count", 64'(starts), 64'd1);
        check("md_wait_quiet",  64'(bad), 64'd0);
        check("md_wb_valid",    64'(wb_valid), 64'd1);
        check("md_wb_data",     wb_data, 64'hFFFF_0000_0000_0001);
        check("md_wb_rd",       64'(wb_rd), 64'd7);
        check("md_wb_we",       64'(wb_we), 64'd1);
        step();
        check("md_retire",      64'(retire_cnt), 64'd4);

        // done on the 64th MD_WAIT cycle beats the timeout
        id_valid = 1'b1; id_is_muldiv = 1'b1; id_rd = 5'd9;
        step();
        id_valid = 1'b0; id_is_muldiv = 1'b0;
        for (int k = 2; k <= 64; k++) step();
        md_done = 1'b1; md_result = 64'h55;
        step();
        md_done = 1'b0;
        check("prec_wb_valid", 64'(wb_valid), 64'd1);
        check("prec_halt",     64'(halt), 64'd0);
        check("prec_flush",    64'(md_flush), 64'd0);
        check("prec_data",     wb_data, 64'h55);
        step();
        check("prec_retire",   64'(retire_cnt), 64'd5);

        // reset while stalled in WB
        wb_ready = 1'b0;
        id_valid = 1'b1; id_rd = 5'd4; alu_result = 64'h77;
        step();
        id_valid = 1'b0;
        check("rwb_valid_pre", 64'(wb_valid), 64'd1);
        do_reset();
        check("rwb_valid",    64'(wb_valid), 64'd0);
        check("rwb_retire",   64'(retire_cnt), 64'd0);
        check("rwb_id_ready", 64'(id_ready), 64'd1);
        check("rwb_flush",    64'(md_flush), 64'd0);
        wb_ready = 1'b1;

        // ebreak + muldiv: ebreak wins
        id_valid = 1'b1; id_ebreak = 1'b1; id_is_muldiv = 1'b1; id_rd = 5'd2;
        step();
        id_ebreak = 1'b0; id_is_muldiv = 1'b0; id_rd = 5'd3; alu_result = 64'h99;
        check("ebk_halt",     64'(halt), 64'd1);
        check("ebk_code",     64'(halt_code), 64'd1);
        check("ebk_retire",   64'(retire_cnt), 64'd1);
        check("ebk_md_start", 64'(md_start), 64'd0);
        check("ebk_id_ready", 64'(id_ready), 64'd0);
        step(); step();
        id_valid = 1'b0;
        check("ebk_sticky",   64'(halt), 64'd1);
        check("ebk_no_wb",    64'(wb_valid), 64'd0);
        check("ebk_retire2",  64'(retire_cnt), 64'd1);
        do_reset();
        check("ebk_cleared",  64'(halt), 64'd0);

        // invalid + ebreak: invalid wins, no retire
        id_valid = 1'b1; id_invalid = 1'b1; id_ebreak = 1'b1;
        step();
        id_valid = 1'b0; id_invalid = 1'b0; id_ebreak = 1'b0;
        check("inv_halt",   64'(halt), 64'd1);
        check("inv_code",   64'(halt_code), 64'd2);
        check("inv_retire", 64'(retire_cnt), 64'd0);
        do_reset();

        // mul/div timeout
        id_valid = 1'b1; id_is_muldiv = 1'b1; id_rd = 5'd6;
        step();
        id_valid = 1'b0; id_is_muldiv = 1'b0;
        bad = 0;
        for (int k = 1; k <= 64; k++) begin
            if (md_flush || wb_valid || halt) bad++;
            step();
        end
        check("tmo_early",    64'(bad), 64'd0);
        check("tmo_flush",    64'(md_flush), 64'd1);
        check("tmo_halt",     64'(halt), 64'd1);
        check("tmo_code",     64'(halt_code), 64'd3);
        check("tmo_md_start", 64'(md_start), 64'd0);
        check("tmo_retire",   64'(retire_cnt), 64'd0);
        step();
        check("tmo_flush_pulse", 64'(md_flush), 64'd0);
        check("tmo_sticky",      64'(halt), 64'd1);
        check("tmo_no_wb",       64'(wb_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
